// File: rtl/alu_regfile_pkg.sv
// ---------------------------------------------------------------------------
// alu_regfile_pkg
// Shared constants and types for the register-file / ALU datapath core.
//   DATA_W        : register and ALU data width
//   REG_ADDR_W    : register address width
//   SHAMT_W       : shift-distance width
//   alu_op_e      : ALU operation encoding (9-15 are unused and yield 0)
//   MODE_UNSIGNED / MODE_SIGNED : meaning of Mode[0]
// ---------------------------------------------------------------------------
package alu_regfile_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SHAMT_W    = 5;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        SLL = 4'd4,
        SRL = 4'd5,
        SRA = 4'd6,
        GT  = 4'd7,
        LT  = 4'd8
    } alu_op_e;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/alu_regfile_core_if.sv
// ---------------------------------------------------------------------------
// alu_regfile_core_if
// Bundles the register-file / ALU control and data signals.
//   master : the controller (CPU decode or testbench) driving addresses,
//            write data, ALU controls and observing results
//   slave  : the alu_regfile_core datapath
// Signals: readreg1, readreg2, writereg, data_in, mux_ctrl, write_enable,
//          Mode, OpCode, Shift_amt (to core); Result, Overflow, readdata1,
//          readdata2 (from core).
// ---------------------------------------------------------------------------
interface alu_regfile_core_if;
    import alu_regfile_pkg::*;

    logic [REG_ADDR_W-1:0] readreg1;
    logic [REG_ADDR_W-1:0] readreg2;
    logic [REG_ADDR_W-1:0] writereg;
    logic [DATA_W-1:0]     data_in;
    logic                  mux_ctrl;
    logic                  write_enable;
    logic [1:0]            Mode;
    logic [3:0]            OpCode;
    logic [SHAMT_W-1:0]    Shift_amt;
    logic [DATA_W-1:0]     Result;
    logic [1:0]            Overflow;
    logic [DATA_W-1:0]     readdata1;
    logic [DATA_W-1:0]     readdata2;

    modport master (
        output readreg1, readreg2, writereg, data_in, mux_ctrl,
               write_enable, Mode, OpCode, Shift_amt,
        input  Result, Overflow, readdata1, readdata2
    );

    modport slave (
        input  readreg1, readreg2, writereg, data_in, mux_ctrl,
               write_enable, Mode, OpCode, Shift_amt,
        output Result, Overflow, readdata1, readdata2
    );

endinterface

// File: rtl/alu_regfile_core_alu32.sv
// ---------------------------------------------------------------------------
// alu32
// Purely combinational 32-bit ALU used as the execute stage.
//   i_a, i_b     : operands (register read ports 1 and 2)
//   i_opcode     : operation select (alu_op_e encoding)
//   i_signed     : 1 = signed arithmetic / compares, 0 = unsigned
//   i_shamt      : shift distance for SLL/SRL/SRA
//   o_result     : operation result
//   o_overflow   : [1] signed overflow, [0] unsigned carry/borrow
//                  (ADD/SUB only, zero otherwise)
// ---------------------------------------------------------------------------
module alu32
    import alu_regfile_pkg::*;
(
    input  logic [DATA_W-1:0]  i_a,
    input  logic [DATA_W-1:0]  i_b,
    input  logic [3:0]         i_opcode,
    input  logic               i_signed,
    input  logic [SHAMT_W-1:0] i_shamt,
    output logic [DATA_W-1:0]  o_result,
    output logic [1:0]         o_overflow
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic            w_addOvf;
    logic            w_subOvf;
    logic            w_gt;
    logic            w_lt;

    // One extra bit on each side gives carry-out for ADD and, for SUB,
    // a set top bit exactly when A < B unsigned (the borrow).
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Signed overflow: ADD needs equal operand signs, SUB needs opposite
    // signs, and in both cases the result sign differs from A.
    assign w_addOvf = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                      (w_sum[DATA_W-1] != i_a[DATA_W-1]);
    assign w_subOvf = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                      (w_diff[DATA_W-1] != i_a[DATA_W-1]);

    assign w_gt = (i_signed == MODE_SIGNED) ? ($signed(i_a) > $signed(i_b)) : (i_a > i_b);
    assign w_lt = (i_signed == MODE_SIGNED) ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

    // Operation select; unused opcodes fall through to the zero defaults.
    always_comb begin
        o_result   = '0;
        o_overflow = 2'b00;
        case (i_opcode)
            ADD: begin
                o_result   = w_sum[DATA_W-1:0];
                o_overflow = (i_signed == MODE_SIGNED) ? {w_addOvf, 1'b0} : {1'b0, w_sum[DATA_W]};
            end
            SUB: begin
                o_result   = w_diff[DATA_W-1:0];
                o_overflow = (i_signed == MODE_SIGNED) ? {w_subOvf, 1'b0} : {1'b0, w_diff[DATA_W]};
            end
            AND: o_result = i_a & i_b;
            OR:  o_result = i_a | i_b;
            SLL: o_result = i_a << i_shamt;
            SRL: o_result = i_a >> i_shamt;
            // SRA always replicates the sign bit, independent of Mode.
            SRA: o_result = $unsigned($signed(i_a) >>> i_shamt);
            GT:  o_result = {{(DATA_W-1){1'b0}}, w_gt};
            LT:  o_result = {{(DATA_W-1){1'b0}}, w_lt};
            default: begin
                o_result   = '0;
                o_overflow = 2'b00;
            end
        endcase
    end

endmodule

// File: rtl/alu_regfile_core.sv
// ---------------------------------------------------------------------------
// alu_regfile_core
// Datapath core: 32 x 32-bit register file (two async read ports, one
// synchronous write port) feeding the alu32 execute stage. Write data is
// selected between external data_in and the ALU Result (write-back).
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset, clears every register
//   bus  : alu_regfile_core_if.slave (addresses, write data/control,
//          ALU controls in; Result, Overflow, readdata1/2 out)
// Optional build macro ALU_ZERO_REG_EN: register 0 is hardwired to zero
// (writes to address 0 dropped, reads of address 0 return 0). Without it
// register 0 is an ordinary register.
// ---------------------------------------------------------------------------
module alu_regfile_core
    import alu_regfile_pkg::*;
#(
    parameter int DATA_W   = alu_regfile_pkg::DATA_W,
    parameter int NUM_REGS = 32
)
(
    input  logic                clk,
    input  logic                rst,
    alu_regfile_core_if.slave   bus
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] w_result;
    logic [DATA_W-1:0] w_wrData;
    logic              w_wrEn;
    logic              w_unused_modeHi;

    // Mode[1] carries no meaning for this core.
    assign w_unused_modeHi = bus.Mode[1];

    // Write-back source uses the Result computed from the current read
    // ports; the loop is broken by the register, so it is stable.
    assign w_wrData = bus.mux_ctrl ? w_result : bus.data_in;

`ifdef ALU_ZERO_REG_EN
    assign w_wrEn          = bus.write_enable && (bus.writereg != '0);
    assign bus.readdata1   = (bus.readreg1 == '0) ? '0 : r_regs[bus.readreg1];
    assign bus.readdata2   = (bus.readreg2 == '0) ? '0 : r_regs[bus.readreg2];
`else
    assign w_wrEn          = bus.write_enable;
    assign bus.readdata1   = r_regs[bus.readreg1];
    assign bus.readdata2   = r_regs[bus.readreg2];
`endif

    // Register file storage: reset wins over a simultaneous write. No
    // read bypass, so a same-cycle read sees the old value until the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wrEn) begin
            r_regs[bus.writereg] <= w_wrData;
        end
    end

    alu32 u_alu (
        .i_a        (bus.readdata1),
        .i_b        (bus.readdata2),
        .i_opcode   (bus.OpCode),
        .i_signed   (bus.Mode[0]),
        .i_shamt    (bus.Shift_amt),
        .o_result   (w_result),
        .o_overflow (bus.Overflow)
    );

    assign bus.Result = w_result;

endmodule

// File: tb/tb_alu_regfile_core.sv
// ---------------------------------------------------------------------------
// tb_alu_regfile_core
// Self-checking bench for alu_regfile_core: directed cases followed by a
// randomized run checked against an arithmetic reference model. Honors the
// ALU_ZERO_REG_EN build macro in its model.
// ---------------------------------------------------------------------------
module tb_alu_regfile_core;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_regfile_core_if busIf ();

    alu_regfile_core dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf)
    );

    always #5 clk = ~clk;

    bit [31:0] modelRegs [32];
    int        checkCount = 0;
    int        passCount  = 0;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    // Single comparison point: counts and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference ALU computed with wide integer arithmetic.
    function automatic void aluModel(input int op, input bit signedMode, input bit [31:0] a,
                                     input bit [31:0] b, input int s,
                                     output bit [31:0] res, output bit [1:0] ovf);
        longint sa, sb, ua, ub, t, d, q;
        sa = $signed(a);
        sb = $signed(b);
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        d  = longint'(1) << s;
        res = 32'd0;
        ovf = 2'b00;
        case (op)
            0: begin
                t = ua + ub;
                res = t[31:0];
                if (signedMode) begin
                    if (sa + sb > SMAX || sa + sb < SMIN) ovf = 2'b10;
                end else if (t > 64'h0000_0000_FFFF_FFFF) begin
                    ovf = 2'b01;
                end
            end
            1: begin
                t = ua - ub;
                res = t[31:0];
                if (signedMode) begin
                    if (sa - sb > SMAX || sa - sb < SMIN) ovf = 2'b10;
                end else if (ua < ub) begin
                    ovf = 2'b01;
                end
            end
            2: res = a & b;
            3: res = a | b;
            4: begin t = ua * d; res = t[31:0]; end
            5: begin t = ua / d; res = t[31:0]; end
            6: begin
                q = sa / d;
                if ((sa % d) != 0 && sa < 0) q = q - 1;
                res = q[31:0];
            end
            7: res = (signedMode ? (sa > sb) : (ua > ub)) ? 32'd1 : 32'd0;
            8: res = (signedMode ? (sa < sb) : (ua < ub)) ? 32'd1 : 32'd0;
            default: begin res = 32'd0; ovf = 2'b00; end
        endcase
    endfunction

    function automatic void modelWrite(input int addr, input bit [31:0] data);
`ifdef ALU_ZERO_REG_EN
        if (addr != 0) modelRegs[addr] = data;
`else
        modelRegs[addr] = data;
`endif
    endfunction

    // Drive read addresses and ALU controls, then let them settle.
    task automatic applyStimulus(input int r1, input int r2, input int op, input int mode, input int s);
        busIf.readreg1     = 5'(r1);
        busIf.readreg2     = 5'(r2);
        busIf.OpCode       = 4'(op);
        busIf.Mode         = 2'(mode);
        busIf.Shift_amt    = 5'(s);
        busIf.write_enable = 1'b0;
        #1;
    endtask

    // Compare readdata and ALU outputs to the model for the current inputs.
    task automatic checkAlu(input string tag);
        bit [31:0] expRes;
        bit [1:0]  expOvf;
        aluModel(int'(busIf.OpCode), busIf.Mode[0], modelRegs[busIf.readreg1],
                 modelRegs[busIf.readreg2], int'(busIf.Shift_amt), expRes, expOvf);
        checkOutput({tag, ".rd1"}, busIf.readdata1, modelRegs[busIf.readreg1]);
        checkOutput({tag, ".rd2"}, busIf.readdata2, modelRegs[busIf.readreg2]);
        checkOutput({tag, ".res"}, busIf.Result, expRes);
        checkOutput({tag, ".ovf"}, {30'd0, busIf.Overflow}, {30'd0, expOvf});
    endtask

    task automatic writeData(input int addr, input bit [31:0] data);
        busIf.writereg     = 5'(addr);
        busIf.data_in      = data;
        busIf.mux_ctrl     = 1'b0;
        busIf.write_enable = 1'b1;
        @(posedge clk);
        #1;
        busIf.write_enable = 1'b0;
        modelWrite(addr, data);
    endtask

    // Write-back of the ALU result for whatever read/op inputs are applied.
    task automatic writeBack(input int addr);
        bit [31:0] expRes;
        bit [1:0]  expOvf;
        aluModel(int'(busIf.OpCode), busIf.Mode[0], modelRegs[busIf.readreg1],
                 modelRegs[busIf.readreg2], int'(busIf.Shift_amt), expRes, expOvf);
        busIf.writereg     = 5'(addr);
        busIf.data_in      = $urandom;
        busIf.mux_ctrl     = 1'b1;
        busIf.write_enable = 1'b1;
        @(posedge clk);
        #1;
        busIf.write_enable = 1'b0;
        busIf.mux_ctrl     = 1'b0;
        modelWrite(addr, expRes);
    endtask

    // Reset with a write attempted in the same cycle; reset must win.
    task automatic doReset();
        rst                = 1'b1;
        busIf.writereg     = 5'd9;
        busIf.data_in      = 32'hDEAD_BEEF;
        busIf.mux_ctrl     = 1'b0;
        busIf.write_enable = 1'b1;
        @(posedge clk);
        #1;
        rst                = 1'b0;
        busIf.write_enable = 1'b0;
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    endtask

    initial begin
        busIf.readreg1     = '0;
        busIf.readreg2     = '0;
        busIf.writereg     = '0;
        busIf.data_in      = '0;
        busIf.mux_ctrl     = 1'b0;
        busIf.write_enable = 1'b0;
        busIf.Mode         = '0;
        busIf.OpCode       = '0;
        busIf.Shift_amt    = '0;
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;

        @(negedge clk);
        doReset();

        // Every register reads zero after reset.
        for (int i = 0; i < 32; i++) begin
            applyStimulus(i, 31 - i, 0, 0, 0);
            checkOutput($sformatf("rst.reg%0d", i), busIf.readdata1, 32'd0);
        end

        // Fill reg[i] = i*101.
        for (int i = 0; i < 10; i++) writeData(i, 32'(i * 101));
        applyStimulus(5, 9, 0, 0, 0);
        checkOutput("fill.reg5", busIf.readdata1, 32'd505);
        checkOutput("fill.reg9", busIf.readdata2, 32'd909);

        writeData(17, 32'h7FFF_FFFF);
        writeData(18, 32'h7FFF_FFFF);
        writeData(20, 32'hFFFF_0218);
        writeData(21, 32'h8000_0000);

        // Directed arithmetic and logic cases with hand-derived results.
        applyStimulus(17, 18, 0, 1, 0);
        checkOutput("addS.ovf.res", busIf.Result, 32'hFFFF_FFFE);
        checkOutput("addS.ovf.flag", {30'd0, busIf.Overflow}, 32'd2);
        applyStimulus(5, 20, 0, 1, 0);
        checkOutput("addS.res", busIf.Result, 32'hFFFF_0411);
        checkOutput("addS.flag", {30'd0, busIf.Overflow}, 32'd0);
        applyStimulus(5, 3, 1, 0, 0);
        checkOutput("subU.res", busIf.Result, 32'd202);
        checkOutput("subU.flag", {30'd0, busIf.Overflow}, 32'd0);
        applyStimulus(5, 20, 1, 1, 0);
        checkOutput("subS.res", busIf.Result, 32'd65505);
        checkOutput("subS.flag", {30'd0, busIf.Overflow}, 32'd0);
        applyStimulus(3, 5, 1, 0, 0);
        checkOutput("subU.brw.res", busIf.Result, 32'hFFFF_FF36);
        checkOutput("subU.brw.flag", {30'd0, busIf.Overflow}, 32'd1);
        applyStimulus(5, 6, 2, 0, 0);
        checkOutput("and", busIf.Result, 32'd88);
        applyStimulus(9, 0, 4, 0, 15);
        checkOutput("sll", busIf.Result, 32'd29786112);
        applyStimulus(21, 0, 5, 0, 31);
        checkOutput("srl", busIf.Result, 32'd1);
        applyStimulus(20, 0, 6, 0, 5);
        checkOutput("sra", busIf.Result, 32'hFFFF_F810);
        applyStimulus(20, 0, 6, 0, 0);
        checkOutput("sra.zero", busIf.Result, 32'hFFFF_0218);
        applyStimulus(20, 1, 7, 1, 0);
        checkOutput("gtS", busIf.Result, 32'd0);
        applyStimulus(20, 1, 8, 1, 0);
        checkOutput("ltS", busIf.Result, 32'd1);
        applyStimulus(6, 7, 8, 0, 0);
        checkOutput("ltU", busIf.Result, 32'd1);
        applyStimulus(20, 1, 8, 0, 0);
        checkOutput("ltU.neg", busIf.Result, 32'd0);
        applyStimulus(5, 3, 12, 1, 3);
        checkOutput("op12.res", busIf.Result, 32'd0);
        checkOutput("op12.flag", {30'd0, busIf.Overflow}, 32'd0);

        // Write-back of reg5 + reg3 into reg31; old value visible before edge.
        applyStimulus(5, 3, 0, 0, 0);
        writeBack(31);
        applyStimulus(31, 5, 0, 0, 0);
        checkOutput("wb.reg31", busIf.readdata1, 32'd808);

        // Write to reg0 through the data_in path.
        writeData(0, 32'd1234);
        applyStimulus(0, 0, 0, 0, 0);
`ifdef ALU_ZERO_REG_EN
        checkOutput("reg0.hard", busIf.readdata1, 32'd0);
`else
        checkOutput("reg0.write", busIf.readdata1, 32'd1234);
`endif

        // Randomized operation/write mix against the model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 31));
            checkAlu($sformatf("rnd%0d", n));
            case ($urandom_range(0, 9))
                0, 1, 2: writeData($urandom_range(0, 31), $urandom);
                3, 4:    writeBack($urandom_range(0, 31));
                5: begin
                    // Write-back into the register feeding operand A.
                    writeBack(int'(busIf.readreg1));
                end
                6: if ($urandom_range(0, 15) == 0) doReset();
                default: ;
            endcase
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
